fix22_to_fp32: RTL and testbench

- Converts the 22-bit signed fixed-point result of the CORDIC cosine stage into IEEE-754 single precision for the floating-point datapath.
- Sits directly downstream of the CORDIC cosine stage: consumes its result word and done strobe, and produces a float word plus its own done strobe.
- Input format is Q2.20 two's complement: bit 21 is the sign, bit 20 the integer bit, bits 19:0 the fraction. Range is [-2.0, 2.0).
- Conversion is always exact, so no rounding is needed: the magnitude is at most 22 bits and fits inside the 24-bit significand.

---
 rtl/fix22_to_fp32.sv | 173 +++++++++++++++++
 tb/tb_fix22_to_fp32.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fix22_to_fp32.sv
// fix22_to_fp32
//
// Converts a Q2.20 two's-complement word (range [-2.0, 2.0)) from the
// CORDIC cosine stage into an IEEE-754 single-precision value. The
// conversion is exact: the 22-bit magnitude always fits in the 24-bit
// significand, so it only has to be normalised, never rounded.
//
// Flow:
//   IDLE - accept a sample, split it into sign and magnitude, and preload
//          the exponent with 128. This is the exponent for a magnitude
//          whose leading one already sits in bit 21.
//          A zero (or flushed) magnitude completes here with +0.0.
//   NORM - shift the magnitude left by up to SHIFTS_PER_CYCLE places per
//          enabled edge. The exponent is decremented once per shift.
//          Once bit 21 is set, the result is written and done is pulsed.
//
// Optional build macro:
//   FIX2FP_FTZ_EN - when defined, any magnitude below 2^-16
//                   (mag[21:4] == 0) is flushed to +0.0 at accept time.
//                   When undefined, every nonzero input down to 2^-20
//                   is converted exactly.
//
// Port names follow the surrounding datapath (clk/reset/clk_en/in_valid/
// fix_in/float_out/done/busy) so the block drops straight in after the
// CORDIC stage.

module fix22_to_fp32 #(
  parameter int SHIFTS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        in_valid,
  input  logic [21:0] fix_in,
  output logic [31:0] float_out,
  output logic        done,
  output logic        busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_NORM = 1'b1
  } state_t;

  // Exponent of a magnitude whose leading one is already in bit 21:
  // bit 21 carries weight 2^1, so the biased exponent is 127 + 1.
  localparam logic [7:0] EXP_TOP = 8'd128;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [21:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] float_q, float_d;
  logic        done_q, done_d;

  logic [21:0] abs_s;
  logic        flush_s;
  logic [21:0] norm_mag_s;
  logic [7:0]  norm_exp_s;

  // Two's-complement magnitude. -2.0 (0x200000) maps onto itself, which
  // is still the correct unsigned value 2.0.
  function automatic logic [21:0] abs22(input logic [21:0] x);
    logic [21:0] r;
    if (x[21]) begin
      r = (~x) + 22'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Magnitude of the incoming word, and whether it completes immediately as +0.0.
  always_comb begin
    abs_s = abs22(fix_in);
`ifdef FIX2FP_FTZ_EN
    flush_s = (abs_s[21:4] == 18'd0);
`else
    flush_s = (abs_s == 22'd0);
`endif
  end

  // One NORM cycle's worth of normalisation: up to SHIFTS_PER_CYCLE single-bit steps.
  always_comb begin
    norm_mag_s = mag_q;
    norm_exp_s = exp_q;
    for (int i = 0; i < SHIFTS_PER_CYCLE; i++) begin
      if (!norm_mag_s[21]) begin
        norm_mag_s = {norm_mag_s[20:0], 1'b0};
        norm_exp_s = norm_exp_s - 8'd1;
      end else begin
        norm_mag_s = norm_mag_s;
        norm_exp_s = norm_exp_s;
      end
    end
  end

  // Next-state and datapath updates. The done pulse drops on every edge; all else waits for clk_en.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    float_d = float_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clk_en && in_valid) begin
          sign_d = fix_in[21];
          mag_d  = abs_s;
          exp_d  = EXP_TOP;
          if (flush_s) begin
            // Zero or flushed input: always +0.0, regardless of sign.
            float_d = 32'h0000_0000;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_NORM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_NORM: begin
        if (clk_en) begin
          mag_d = norm_mag_s;
          exp_d = norm_exp_s;
          if (norm_mag_s[21]) begin
            // Bit 21 is the hidden one; the 21 bits below it are the
            // top of the fraction. Two zero bits pad the fraction to 23.
            float_d = {sign_q, norm_exp_s, norm_mag_s[20:0], 2'b00};
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_NORM;
          end
        end else begin
          state_d = ST_NORM;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything and aborts any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      mag_q   <= 22'd0;
      exp_q   <= 8'd0;
      float_q <= 32'h0000_0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      float_q <= float_d;
      done_q  <= done_d;
    end
  end

  assign float_out = float_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_NORM);

endmodule

// File: tb/tb_fix22_to_fp32.sv
// Directed testbench for fix22_to_fp32 (SHIFTS_PER_CYCLE = 4).
// The expected values are hand-computed IEEE-754 encodings of each Q2.20
// input.
// "lat" is the number of edges after the accepting edge until done is
// seen. A zero or flushed input completes on the accepting edge itself,
// which gives lat 0.
module tb_fix22_to_fp32;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        in_valid;
  logic [21:0] fix_in;
  logic [31:0] float_out;
  logic        done;
  logic        busy;

  int n_checks;
  int n_fail;

  fix22_to_fp32 #(.SHIFTS_PER_CYCLE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .fix_in    (fix_in),
    .float_out (float_out),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for done; returns the number of edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic convert(input string tag, input logic [21:0] x,
                         input logic [31:0] expf, input int explat);
    int n;
    fix_in   = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, (explat != 0)});
    wait_done(n);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_lat"}, n, explat);
    check({tag, "_val"}, float_out, expf);
    tick();
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, float_out, expf);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clk_en   = 1'b1;
    in_valid = 1'b0;
    fix_in   = 22'd0;
    #12;
    check("rst_float", float_out, 32'h0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    convert("one",   22'h100000, 32'h3F80_0000, 1);
    convert("gainK", 22'h09B74E, 32'h3F1B_74E0, 1);
    convert("neg1",  22'h300000, 32'hBF80_0000, 1);
    convert("neg2",  22'h200000, 32'hC000_0000, 1);
    convert("zero",  22'h000000, 32'h0000_0000, 0);
`ifdef FIX2FP_FTZ_EN
    convert("lsb",   22'h000001, 32'h0000_0000, 0);
`else
    convert("lsb",   22'h000001, 32'h3580_0000, 6);
`endif
    convert("x10",   22'h000010, 32'h3780_0000, 5);
    convert("negsm", 22'h3FFFF0, 32'hB780_0000, 5);

    // in_valid ignored in IDLE while clk_en is low
    clk_en   = 1'b0;
    fix_in   = 22'h100000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ce0_busy", {31'd0, busy}, 32'd0);
    check("ce0_done", {31'd0, done}, 32'd0);
    clk_en = 1'b1;

`ifndef FIX2FP_FTZ_EN
    // clk_en held low for 3 edges mid-NORM stretches 6 edges to 9
    fix_in   = 22'h000001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clk_en = 1'b0;
    tick();
    tick();
    tick();
    check("stall_busy", {31'd0, busy}, 32'd1);
    check("stall_done", {31'd0, done}, 32'd0);
    clk_en = 1'b1;
    wait_done(n);
    check("stall_lat", n + 5, 32'd9);
    check("stall_val", float_out, 32'h3580_0000);
    // done still clears on an edge with clk_en low
    clk_en = 1'b0;
    tick();
    check("stall_clr", {31'd0, done}, 32'd0);
    check("stall_hold", float_out, 32'h3580_0000);
    clk_en = 1'b1;
`endif

    // in_valid pulsed while busy is ignored
    fix_in   = 22'h000010;
    in_valid = 1'b1;
    tick();
    fix_in   = 22'h100000;
    tick();
    in_valid = 1'b0;
    wait_done(n);
    check("busy_lat", n + 1, 32'd5);
    check("busy_val", float_out, 32'h3780_0000);
    for (int i = 0; i < 4; i++) tick();
    check("busy_nodone", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("busy_hold", float_out, 32'h3780_0000);

    // reset during NORM aborts immediately
    fix_in   = 22'h000001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_float", float_out, 32'h0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    #1;
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) n++;
    end
    check("arst_nodone", n, 32'd0);

    // back-to-back: second input presented on the edge after done rises
    fix_in   = 22'h100000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(n);
    check("b2b1_val", float_out, 32'h3F80_0000);
    fix_in   = 22'h300000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("b2b2_busy", {31'd0, busy}, 32'd1);
    check("b2b2_nodone", {31'd0, done}, 32'd0);
    wait_done(n);
    check("b2b2_lat", n, 32'd1);
    check("b2b2_val", float_out, 32'hBF80_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
